// File: rtl/cpu_mem_sched.sv
// cpu_mem_sched: one memory port shared by instruction fetch and load/store,
// with fair arbitration, a watchdog abort and a combined pipeline stall.
module cpu_mem_sched #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_ready,
  output logic                if_err,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_rd,
  input  logic                d_wr,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_ready,
  output logic                d_err,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_ready,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                stall
);

  localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WDW-1:0] WD_LAST =
    (TIMEOUT > 0) ? WDW'(TIMEOUT - 1) : '0;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]     state;
  logic           lastGrant;
  logic           owner;
  logic [WDW-1:0] wdCnt;

  logic dReq;
  logic anyReq;
  logic grant;
  logic grantData;
  logic wdExpire;
  logic done;
  logic abort;

  // lastGrant and owner use 1 for the data side, 0 for fetch
  assign dReq      = d_rd | d_wr;
  assign anyReq    = if_req | dReq;
  assign grant     = (state == IDLE) & anyReq;
  assign grantData = dReq & ~(if_req & lastGrant);
  assign wdExpire  = (TIMEOUT != 0) && (wdCnt == WD_LAST);
  assign done      = (state == BUSY) & mem_ready;
  assign abort     = (state == BUSY) & ~mem_ready & wdExpire;
  assign stall     = (if_req & ~if_ready) | (dReq & ~d_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      lastGrant <= 1'b0;
      owner     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (anyReq) begin
            state     <= BUSY;
            owner     <= grantData;
            lastGrant <= grantData;
          end
        end
        BUSY: begin
          if (done | abort) state <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // a simultaneous load+store request is issued as a store
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else if (grant) begin
      mem_req   <= 1'b1;
      mem_we    <= grantData & d_wr;
      mem_addr  <= grantData ? d_addr : if_addr;
      mem_wdata <= grantData ? d_wdata : '0;
      mem_wstrb <= (grantData & d_wr) ? d_wstrb : '0;
    end else if (done | abort) begin
      mem_req <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || state != BUSY) begin
      wdCnt <= '0;
    end else if (TIMEOUT != 0 && !wdExpire) begin
      wdCnt <= wdCnt + 1'b1;
    end
  end

  // an aborted access pulses ready+err but leaves read data untouched
  always_ff @(posedge clk) begin
    if (rst) begin
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
      if_err   <= 1'b0;
      d_err    <= 1'b0;
      if_rdata <= '0;
      d_rdata  <= '0;
    end else begin
      if_ready <= (done | abort) & ~owner;
      d_ready  <= (done | abort) & owner;
      if_err   <= abort & ~owner;
      d_err    <= abort & owner;
      if (done & ~owner) if_rdata <= mem_rdata;
      if (done & owner & ~mem_we) d_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_cpu_mem_sched.sv
// tb_cpu_mem_sched: directed and random traffic checked against a
// transaction-level model of grant order, latency and response data.
module tb_cpu_mem_sched;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ready;
  logic          if_err;
  logic [DW-1:0] if_rdata;
  logic          d_rd;
  logic          d_wr;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [SW-1:0] d_wstrb;
  logic          d_ready;
  logic          d_err;
  logic [DW-1:0] d_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [SW-1:0] mem_wstrb;
  logic          mem_ready;
  logic [DW-1:0] mem_rdata;
  logic          stall;

  logic          zRst;
  logic          zIfReq;
  logic [AW-1:0] zIfAddr;
  logic          zIfReady;
  logic          zIfErr;
  logic [DW-1:0] zIfRdata;
  logic          zDRd;
  logic          zDWr;
  logic [AW-1:0] zDAddr;
  logic [DW-1:0] zDWdata;
  logic [SW-1:0] zDWstrb;
  logic          zDReady;
  logic          zDErr;
  logic [DW-1:0] zDRdata;
  logic          zMemReq;
  logic          zMemWe;
  logic [AW-1:0] zMemAddr;
  logic [DW-1:0] zMemWdata;
  logic [SW-1:0] zMemWstrb;
  logic          zMemReady;
  logic [DW-1:0] zMemRdata;
  logic          zStall;

  always #5 clk = ~clk;

  cpu_mem_sched #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
    .if_err(if_err), .if_rdata(if_rdata),
    .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wstrb(d_wstrb), .d_ready(d_ready), .d_err(d_err),
    .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .stall(stall)
  );

  cpu_mem_sched #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(0)) dut0 (
    .clk(clk), .rst(zRst),
    .if_req(zIfReq), .if_addr(zIfAddr), .if_ready(zIfReady),
    .if_err(zIfErr), .if_rdata(zIfRdata),
    .d_rd(zDRd), .d_wr(zDWr), .d_addr(zDAddr), .d_wdata(zDWdata),
    .d_wstrb(zDWstrb), .d_ready(zDReady), .d_err(zDErr),
    .d_rdata(zDRdata),
    .mem_req(zMemReq), .mem_we(zMemWe), .mem_addr(zMemAddr),
    .mem_wdata(zMemWdata), .mem_wstrb(zMemWstrb),
    .mem_ready(zMemReady), .mem_rdata(zMemRdata),
    .stall(zStall)
  );

  int nChk  = 0;
  int nPass = 0;
  int cyc   = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    nChk++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  tag, got, exp, cyc);
  endtask

  // requester state
  bit            fPend;
  logic [AW-1:0] fAddr;
  bit            dPend;
  bit            dRd;
  bit            dWr;
  logic [AW-1:0] dAddr;
  logic [DW-1:0] dWdata;
  logic [SW-1:0] dWstrb;

  // reference model: one outstanding transaction described by cycle numbers
  bit            active;
  bit            owner;
  bit            errExp;
  bit            lastD;
  bit            expWe;
  int            startCyc;
  int            readyCyc;
  int            lat;
  logic [AW-1:0] expAddr;
  logic [DW-1:0] expWdata;
  logic [SW-1:0] expWstrb;
  logic [DW-1:0] rdVal;
  logic [DW-1:0] expIf;
  logic [DW-1:0] expD;

  bit            autoReq;
  int            forceLat;
  bit            useForceRd;
  logic [DW-1:0] forceRd;
  int            reissueD;
  logic [AW-1:0] grants[$];

  task automatic newFetch();
    fPend = 1'b1;
    fAddr = $urandom;
  endtask

  task automatic newData();
    int k;
    k      = $urandom_range(0, 3);
    dPend  = 1'b1;
    dRd    = (k != 1);
    dWr    = (k == 1) || (k == 3);
    dAddr  = $urandom;
    dWdata = $urandom;
    dWstrb = SW'($urandom);
  endtask

  task automatic grantModel();
    bit pickD;
    if (fPend && dPend) pickD = !lastD;
    else pickD = dPend;
    lastD    = pickD;
    owner    = pickD;
    active   = 1'b1;
    startCyc = cyc;
    lat      = (forceLat >= 0) ? forceLat : $urandom_range(0, 5);
    // memory answers in BUSY cycle lat+1; past TO cycles it is an abort
    errExp   = (lat >= TO);
    readyCyc = errExp ? cyc + TO + 1 : cyc + lat + 2;
    expWe    = pickD && dWr;
    expAddr  = pickD ? dAddr : fAddr;
    expWdata = dWdata;
    expWstrb = expWe ? dWstrb : '0;
    rdVal    = useForceRd ? forceRd : $urandom;
  endtask

  task automatic resetModel();
    active = 1'b0;
    fPend  = 1'b0;
    dPend  = 1'b0;
    lastD  = 1'b0;
    expIf  = '0;
    expD   = '0;
  endtask

  task automatic runCycle();
    bit busy;
    bit ifRdy;
    bit dRdy;
    @(posedge clk);
    #1;
    cyc++;
    rst = 1'b0;
    if (active && cyc == readyCyc + 1) begin
      active = 1'b0;
      if (owner) begin
        dPend = 1'b0;
        if (reissueD > 0) begin
          reissueD--;
          dPend = 1'b1;
          dAddr = dAddr + 4;
        end
      end else begin
        fPend = 1'b0;
      end
    end
    if (autoReq) begin
      if (!fPend && $urandom_range(0, 2) == 0) newFetch();
      if (!dPend && $urandom_range(0, 2) == 0) newData();
    end
    if (!active && (fPend || dPend)) grantModel();
    busy = active && cyc > startCyc && cyc < readyCyc;
    if (busy) mem_ready = !errExp && cyc == startCyc + lat + 1;
    else mem_ready = 1'($urandom_range(0, 1));
    mem_rdata = (busy && mem_ready) ? rdVal : $urandom;
    if_req  = fPend;
    if_addr = fAddr;
    d_rd    = dPend && dRd;
    d_wr    = dPend && dWr;
    d_addr  = dAddr;
    d_wdata = dWdata;
    d_wstrb = dWstrb;
    @(negedge clk);
    ifRdy = active && cyc == readyCyc && !owner;
    dRdy  = active && cyc == readyCyc && owner;
    if (ifRdy && !errExp) expIf = rdVal;
    if (dRdy && !errExp && !expWe) expD = rdVal;
    chk("mem_req", mem_req, busy);
    if (busy) begin
      chk("mem_addr", mem_addr, expAddr);
      chk("mem_we", mem_we, expWe);
      chk("mem_wstrb", mem_wstrb, expWstrb);
      if (expWe) chk("mem_wdata", mem_wdata, expWdata);
      if (cyc == startCyc + 1) grants.push_back(mem_addr);
    end
    chk("if_ready", if_ready, ifRdy);
    chk("d_ready", d_ready, dRdy);
    if (ifRdy) chk("if_err", if_err, errExp);
    if (dRdy) chk("d_err", d_err, errExp);
    chk("if_rdata", if_rdata, expIf);
    chk("d_rdata", d_rdata, expD);
    chk("stall", stall, (fPend && !ifRdy) || (dPend && !dRdy));
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    cyc++;
    rst       = 1'b1;
    mem_ready = 1'b0;
    @(negedge clk);
    resetModel();
  endtask

  task automatic runN(input int n);
    for (int i = 0; i < n; i++) runCycle();
  endtask

  logic [DW-1:0] saved;

  initial begin
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0;
    d_rd = 1'b0; d_wr = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    zRst = 1'b1; zIfReq = 1'b0; zIfAddr = '0;
    zDRd = 1'b0; zDWr = 1'b0; zDAddr = '0; zDWdata = '0; zDWstrb = '0;
    zMemReady = 1'b0; zMemRdata = '0;
    resetModel();
    autoReq = 1'b0; forceLat = -1; useForceRd = 1'b0;
    forceRd = '0; reissueD = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst mem_req", mem_req, 0);
    chk("rst mem_we", mem_we, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst mem_wdata", mem_wdata, 0);
    chk("rst mem_wstrb", mem_wstrb, 0);
    chk("rst if_ready", if_ready, 0);
    chk("rst d_ready", d_ready, 0);
    chk("rst if_err", if_err, 0);
    chk("rst d_err", d_err, 0);
    chk("rst if_rdata", if_rdata, 0);
    chk("rst d_rdata", d_rdata, 0);

    // single zero-wait fetch
    useForceRd = 1'b1;
    forceRd = 32'hDEADBEEF;
    forceLat = 0;
    fPend = 1'b1; fAddr = 32'h100;
    grants.delete();
    runN(4);
    chk("fetch grants", grants.size(), 1);
    if (grants.size() > 0) chk("fetch addr", grants[0], 32'h100);
    chk("fetch rdata", if_rdata, 32'hDEADBEEF);

    // contention from reset: data first, then fetch wins the rematch
    doReset();
    forceRd = 32'hA5A5_0001;
    fPend = 1'b1; fAddr = 32'h200;
    dPend = 1'b1; dRd = 1'b1; dWr = 1'b0; dAddr = 32'h8000;
    reissueD = 1;
    grants.delete();
    runN(10);
    chk("contend grants", grants.size(), 3);
    if (grants.size() == 3) begin
      chk("contend 1st", grants[0], 32'h8000);
      chk("contend 2nd", grants[1], 32'h200);
      chk("contend 3rd", grants[2], 32'h8004);
    end

    // store with strobes, answered on the watchdog's last cycle
    saved = expD;
    forceLat = 3;
    dPend = 1'b1; dRd = 1'b0; dWr = 1'b1; dAddr = 32'h40;
    dWdata = 32'h12345678; dWstrb = 4'b0011;
    grants.delete();
    runN(7);
    chk("store grants", grants.size(), 1);
    chk("store d_rdata", d_rdata, saved);

    // load that times out
    forceLat = 5;
    dPend = 1'b1; dRd = 1'b1; dWr = 1'b0; dAddr = 32'h80;
    runN(7);
    chk("tmo d_rdata", d_rdata, saved);

    // load and store together behave as one store
    forceLat = 1;
    dPend = 1'b1; dRd = 1'b1; dWr = 1'b1; dAddr = 32'hC0;
    dWdata = 32'hCAFE0000; dWstrb = 4'b1111;
    runN(5);
    chk("rdwr d_rdata", d_rdata, saved);

    // reset during BUSY, then fair grant restarts from fetch
    forceLat = 5;
    dPend = 1'b1; dRd = 1'b1; dWr = 1'b0; dAddr = 32'h1000;
    runN(3);
    doReset();
    runCycle();
    chk("mrst mem_addr", mem_addr, 0);
    chk("mrst mem_we", mem_we, 0);
    chk("mrst mem_wstrb", mem_wstrb, 0);
    forceLat = 0;
    forceRd = 32'h0BADF00D;
    fPend = 1'b1; fAddr = 32'h500;
    dPend = 1'b1; dRd = 1'b1; dWr = 1'b0; dAddr = 32'h9000;
    grants.delete();
    runN(7);
    chk("mrst grants", grants.size(), 2);
    if (grants.size() == 2) begin
      chk("mrst 1st", grants[0], 32'h9000);
      chk("mrst 2nd", grants[1], 32'h500);
    end
    chk("mrst if_rdata", if_rdata, 32'h0BADF00D);

    // random traffic with occasional mid-flight resets
    autoReq = 1'b1;
    forceLat = -1;
    useForceRd = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (active && $urandom_range(0, 199) == 0) doReset();
      else runCycle();
    end
    autoReq = 1'b0;
    fPend = 1'b0;
    dPend = 1'b0;
    runN(8);

    // watchdog disabled: a 40-cycle wait still completes normally
    @(posedge clk);
    #1;
    zRst = 1'b0; zIfReq = 1'b1; zIfAddr = 32'h300; zMemReady = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      zMemReady = (i == 40);
      zMemRdata = (i == 40) ? 32'hCAFEF00D : $urandom;
      @(negedge clk);
      chk("wd0 mem_req", zMemReq, 1);
      chk("wd0 if_ready", zIfReady, 0);
      chk("wd0 stall", zStall, 1);
    end
    chk("wd0 mem_addr", zMemAddr, 32'h300);
    chk("wd0 mem_we", zMemWe, 0);
    chk("wd0 mem_wstrb", zMemWstrb, 0);
    chk("wd0 mem_wdata", zMemWdata, 0);
    @(posedge clk);
    #1;
    zMemReady = 1'b0;
    @(negedge clk);
    chk("wd0 ready", zIfReady, 1);
    chk("wd0 err", zIfErr, 0);
    chk("wd0 rdata", zIfRdata, 32'hCAFEF00D);
    chk("wd0 ready stall", zStall, 0);
    @(posedge clk);
    #1;
    zIfReq = 1'b0;
    @(negedge clk);
    chk("wd0 idle req", zMemReq, 0);
    chk("wd0 idle ready", zIfReady, 0);
    chk("wd0 d_ready", zDReady, 0);
    chk("wd0 d_err", zDErr, 0);
    chk("wd0 d_rdata", zDRdata, 0);

    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end

endmodule
